// File: rtl/real_value.sv
// real_value: scales an IEEE-754 binary32 operand by 2^b with one register stage.
// Specials pass through. Subnormals are normalized on input and produced on output.
// Overflow either saturates to infinity or to max finite. Underflow truncates toward zero.
module real_value #(
   parameter bit SAT_INF = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] data,
   input  logic [6:0]  b,
   output logic [31:0] shifted
);

   localparam int unsigned FRAC_W = 23;
   localparam int unsigned EXP_W  = 8;
   localparam int unsigned MANT_W = FRAC_W + 1;
   localparam int unsigned LZ_W   = 5;
   localparam int unsigned ADJ_W  = 10;

   logic                     w_sign;
   logic [EXP_W-1:0]         w_exp;
   logic [FRAC_W-1:0]        w_frac;
   logic                     w_is_special;
   logic [LZ_W-1:0]          w_lz;
   logic                     w_lz_found;
   logic [FRAC_W-1:0]        w_frac_norm;
   logic [MANT_W-1:0]        w_mant;
   logic signed [ADJ_W-1:0]  w_exp_eff;
   logic signed [ADJ_W-1:0]  w_b_ext;
   logic signed [ADJ_W-1:0]  w_exp_adj;
   logic [ADJ_W-1:0]         w_sh;
   logic [MANT_W-1:0]        w_mant_sh;
   logic [31:0]              w_result;
   logic [31:0]              r_shifted;

   assign w_sign       = data[31];
   assign w_exp        = data[30:23];
   assign w_frac       = data[22:0];
   assign w_is_special = (w_exp == 8'hFF) || ((w_exp == 8'h00) && (w_frac == 23'h0));

   // Leading-zero count of the fraction, used only to normalize subnormal inputs
   always_comb begin
      w_lz       = '0;
      w_lz_found = 1'b0;
      for (int i = FRAC_W - 1; i >= 0; i--) begin
         if (!w_lz_found && w_frac[i]) begin
            w_lz       = LZ_W'(FRAC_W - 1 - i);
            w_lz_found = 1'b1;
         end
      end
   end

   // Normalize, adjust the exponent, and select normal / overflow / subnormal result
   always_comb begin
      w_frac_norm = FRAC_W'(w_frac << (w_lz + 5'd1));
      w_b_ext     = ADJ_W'(signed'({{(ADJ_W-7){b[6]}}, b}));
      if (w_exp == 8'h00) begin
         w_mant    = {1'b1, w_frac_norm};
         w_exp_eff = -ADJ_W'(signed'({{(ADJ_W-LZ_W){1'b0}}, w_lz}));
      end else begin
         w_mant    = {1'b1, w_frac};
         w_exp_eff = ADJ_W'(signed'({{(ADJ_W-EXP_W){1'b0}}, w_exp}));
      end
      w_exp_adj = w_exp_eff + w_b_ext;
      w_sh      = ADJ_W'(10'sd1 - w_exp_adj);
      w_mant_sh = (w_sh >= 10'd24) ? '0 : MANT_W'(w_mant >> w_sh);
      w_result  = data;

      if (!w_is_special) begin
         if (w_exp_adj >= 10'sd255) begin
            if (SAT_INF) w_result = {w_sign, 8'hFF, 23'h000000};
            else         w_result = {w_sign, 8'hFE, 23'h7FFFFF};
         end else if (w_exp_adj >= 10'sd1) begin
            w_result = {w_sign, w_exp_adj[7:0], w_mant[22:0]};
         end else begin
            w_result = {w_sign, 8'h00, w_mant_sh[22:0]};
         end
      end
   end

   // Single output register; synchronous reset clears the result
   always_ff @(posedge clk) begin
      if (!rst_n) r_shifted <= 32'h0000_0000;
      else        r_shifted <= w_result;
   end

   assign shifted = r_shifted;

endmodule

// File: tb/tb_real_value.sv
// tb_real_value: directed and random checks of real_value for both overflow modes.
module tb_real_value;

   logic        clk;
   logic        rst_n;
   logic [31:0] data;
   logic [6:0]  b;
   logic [31:0] shifted_inf;
   logic [31:0] shifted_max;

   int n_checks;
   int n_errors;

   real_value #(.SAT_INF(1'b1)) dut_inf (
      .clk     (clk),
      .rst_n   (rst_n),
      .data    (data),
      .b       (b),
      .shifted (shifted_inf)
   );

   real_value #(.SAT_INF(1'b0)) dut_max (
      .clk     (clk),
      .rst_n   (rst_n),
      .data    (data),
      .b       (b),
      .shifted (shifted_max)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_errors++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, expv);
      end
   endtask

   function automatic real pow2(input int k);
      real r;
      r = 1.0;
      if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
      else        for (int i = 0; i < -k; i++) r = r / 2.0;
      return r;
   endfunction

   // Real-number reference: decode, multiply by 2^b, re-encode truncating toward zero
   function automatic logic [31:0] model(input logic [31:0] d, input logic [6:0] bb, input bit sat_inf);
      int   sb;
      int   ex;
      int   mant;
      int   k;
      int   fr;
      real  x;
      real  p;
      logic s;
      s  = d[31];
      sb = bb[6] ? int'(bb) - 128 : int'(bb);
      if (d[30:23] == 8'hFF || d[30:0] == 31'h0) return d;
      if (d[30:23] == 8'h00) begin
         mant = int'(d[22:0]);
         ex   = -149;
      end else begin
         mant = int'(d[22:0]) + (1 << 23);
         ex   = int'(d[30:23]) - 150;
      end
      x = real'(mant) * pow2(ex + sb);
      p = 1.0;
      k = 0;
      while (x >= 2.0 * p) begin p = p * 2.0; k++; end
      while (x < p)        begin p = p / 2.0; k--; end
      if (k > 127) begin
         if (sat_inf) return {s, 8'hFF, 23'h0};
         return {s, 8'hFE, 23'h7FFFFF};
      end
      if (k >= -126) begin
         fr = $rtoi((x / p - 1.0) * 8388608.0);
         return {s, 8'(k + 127), 23'(fr)};
      end
      fr = $rtoi(x * pow2(149));
      return {s, 8'h00, 23'(fr)};
   endfunction

   typedef struct {
      logic [31:0] d;
      logic [6:0]  bb;
      logic [31:0] e_inf;
      logic [31:0] e_max;
      string       tag;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [31:0] rd;
      logic [6:0]  rb;
      logic [31:0] m_inf;
      logic [31:0] m_max;
      n_checks = 0;
      n_errors = 0;

      vecs.push_back('{32'h3F800000, 7'd3,   32'h41000000, 32'h41000000, "one_x8"});
      vecs.push_back('{32'h40400000, 7'h7E,  32'h3F400000, 32'h3F400000, "three_div4"});
      vecs.push_back('{32'h7F000000, 7'd2,   32'h7F800000, 32'h7F7FFFFF, "ovf_pos"});
      vecs.push_back('{32'hFF000000, 7'd63,  32'hFF800000, 32'hFF7FFFFF, "ovf_neg_b63"});
      vecs.push_back('{32'h00800000, 7'h7F,  32'h00400000, 32'h00400000, "min_norm_to_sub"});
      vecs.push_back('{32'h00800000, 7'h68,  32'h00000000, 32'h00000000, "underflow_b_m24"});
      vecs.push_back('{32'h80800000, 7'h40,  32'h80000000, 32'h80000000, "underflow_neg_b_m64"});
      vecs.push_back('{32'h00000001, 7'd23,  32'h00800000, 32'h00800000, "sub_to_norm"});
      vecs.push_back('{32'h00400000, 7'd0,   32'h00400000, 32'h00400000, "sub_b0"});
      vecs.push_back('{32'h7FC00001, 7'd5,   32'h7FC00001, 32'h7FC00001, "nan_payload"});
      vecs.push_back('{32'hFF800000, 7'h79,  32'hFF800000, 32'hFF800000, "neg_inf"});
      vecs.push_back('{32'h80000000, 7'd10,  32'h80000000, 32'h80000000, "neg_zero"});
      vecs.push_back('{32'h00000003, 7'h7F,  32'h00000001, 32'h00000001, "sub_truncate"});
      vecs.push_back('{32'h007FFFFF, 7'd1,   32'h00FFFFFE, 32'h00FFFFFE, "max_sub_x2"});
      vecs.push_back('{32'h7F7FFFFF, 7'd0,   32'h7F7FFFFF, 32'h7F7FFFFF, "max_finite_b0"});
      vecs.push_back('{32'h3F800000, 7'd63,  32'h5F000000, 32'h5F000000, "one_b63"});
      vecs.push_back('{32'hBF800000, 7'h40,  32'h9F800000, 32'h9F800000, "neg_one_b_m64"});
      vecs.push_back('{32'h7F7FFFFF, 7'd1,   32'h7F800000, 32'h7F7FFFFF, "max_finite_ovf"});

      // Reset wins even with live operands
      rst_n = 1'b0;
      data  = 32'h3F800000;
      b     = 7'd3;
      @(posedge clk); #1;
      check("reset_inf", shifted_inf, 32'h0);
      check("reset_max", shifted_max, 32'h0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         data = vecs[i].d;
         b    = vecs[i].bb;
         @(posedge clk); #1;
         check({vecs[i].tag, "_inf"}, shifted_inf, vecs[i].e_inf);
         check({vecs[i].tag, "_max"}, shifted_max, vecs[i].e_max);
      end

      // Back-to-back random operands, new pair every cycle
      for (int n = 0; n < 100; n++) begin
         rd = $urandom;
         rb = 7'($urandom);
         case (n % 4)
            0: rd[30:23] = 8'($urandom_range(0, 3));
            1: rd[30:23] = 8'($urandom_range(240, 254));
            2: rd[30:23] = 8'($urandom_range(1, 40));
            default: ;
         endcase
         if (n % 10 == 5) rd[30:23] = 8'h00;
         data  = rd;
         b     = rb;
         m_inf = model(rd, rb, 1'b1);
         m_max = model(rd, rb, 1'b0);
         @(posedge clk); #1;
         check($sformatf("rand%0d_inf d=%08h b=%02h", n, rd, rb), shifted_inf, m_inf);
         check($sformatf("rand%0d_max d=%08h b=%02h", n, rd, rb), shifted_max, m_max);
      end

      // Mid-stream reset, then recovery on the next edge
      rst_n = 1'b0;
      data  = 32'h7F000000;
      b     = 7'd2;
      @(posedge clk); #1;
      check("midreset_inf", shifted_inf, 32'h0);
      check("midreset_max", shifted_max, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_inf", shifted_inf, 32'h7F800000);
      check("post_reset_max", shifted_max, 32'h7F7FFFFF);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
